pipe_adder: RTL and testbench



---
 rtl/pipe_adder_pkg.sv | 19 +
 rtl/adder_seg.sv | 33 +++
 rtl/pipe_adder.sv | 123 ++++++++++++
 tb/tb_pipe_adder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared configuration for the pipelined adder: default geometry, a
// configuration sanity check and the per-stage control record.
package pipe_adder_pkg;

    localparam int PA_DEF_WIDTH  = 16;
    localparam int PA_DEF_STAGES = 4;

    // Control half of a stage payload; the data half (partial sum and the
    // pending operand bits) shrinks/grows per stage and lives in the top.
    typedef struct packed {
        logic vld;
        logic carry;
    } stage_ctl_t;

    function automatic bit pa_cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational W-bit ripple of full-adder cells. With PIPE_ADDER_OVF_EN the
// carry into the MSB is also exported so the caller can derive overflow.
module adder_seg #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
`ifdef PIPE_ADDER_OVF_EN
    output logic         cmsb_o,
`endif
    output logic         cout_o
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = cin_i;
        for (int i = 0; i < W; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c[W];
`ifdef PIPE_ADDER_OVF_EN
    assign cmsb_o = c[W-1];
`endif

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder, one SEG-bit segment per stage, valid/ready on
// both sides. Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = PA_DEF_WIDTH,
    parameter int STAGES = PA_DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int SEG = WIDTH / STAGES;

    if (!pa_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: STAGES must be in 1..WIDTH and divide WIDTH");
    end

    // Handshake: a beat moves on an edge where valid & ready are both high.
    // The whole pipe advances together; it only freezes when the last stage
    // holds a result the consumer has not taken.
    logic adv;
    assign adv      = out_ready | ~g_stage[STAGES-1].ctl_q.vld;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k * SEG;

        logic [REM-1:0]         a_src, b_src;
        logic                   c_src, v_src;
        logic [SEG-1:0]         seg_s;
        logic                   seg_c;
        logic [(k+1)*SEG-1:0]   psum_d, psum_q;
        stage_ctl_t             ctl_d, ctl_q;
`ifdef PIPE_ADDER_OVF_EN
        logic                   seg_cmsb;
`endif

        if (k == 0) begin : g_src
            assign a_src  = a;
            assign b_src  = b;
            assign c_src  = cin;
            assign v_src  = in_valid;
            assign psum_d = seg_s;
        end else begin : g_src
            assign a_src  = g_stage[k-1].g_pend.a_pend_q;
            assign b_src  = g_stage[k-1].g_pend.b_pend_q;
            assign c_src  = g_stage[k-1].ctl_q.carry;
            assign v_src  = g_stage[k-1].ctl_q.vld;
            assign psum_d = {seg_s, g_stage[k-1].psum_q};
        end

        adder_seg #(.W(SEG)) u_seg (
            .a_i    (a_src[SEG-1:0]),
            .b_i    (b_src[SEG-1:0]),
            .cin_i  (c_src),
            .s_o    (seg_s),
`ifdef PIPE_ADDER_OVF_EN
            .cmsb_o (seg_cmsb),
`endif
            .cout_o (seg_c)
        );

        assign ctl_d = '{vld: v_src, carry: seg_c};

        always_ff @(posedge clk) begin
            if (rst) begin
                ctl_q  <= '0;
                psum_q <= '0;
            end else if (adv) begin
                ctl_q  <= ctl_d;
                psum_q <= psum_d;
            end
        end

        // Operand skew: only the bits later stages still need travel onward.
        if (k < STAGES - 1) begin : g_pend
            logic [REM-SEG-1:0] a_pend_q, b_pend_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_pend_q <= '0;
                    b_pend_q <= '0;
                end else if (adv) begin
                    a_pend_q <= a_src[REM-1:SEG];
                    b_pend_q <= b_src[REM-1:SEG];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].ctl_q.vld;
    assign sum       = g_stage[STAGES-1].psum_q;
    assign cout      = g_stage[STAGES-1].ctl_q.carry;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d, ovf_q;
    assign ovf_d = g_stage[STAGES-1].seg_cmsb ^ g_stage[STAGES-1].seg_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: 16/4 main instance plus 8/1 and 32/8
// instances for the geometry sweep. Honours PIPE_ADDER_OVF_EN.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int W = 16;
  localparam int S = 4;

  typedef logic [W+1:0] res_t;  // {ovf, cout, sum}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_sw = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
  logic         ovf_bit;
`ifdef PIPE_ADDER_OVF_EN
  logic         ovf;
  assign ovf_bit = ovf;
`else
  assign ovf_bit = 1'b0;
`endif

  pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum),
`ifdef PIPE_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  // ---------------- sweep DUTs ----------------
  logic        v8_iv, v8_ir, v8_c, v8_ov, v8_co;
  logic [7:0]  v8_a, v8_b, v8_s;
  logic        v32_iv, v32_ir, v32_c, v32_ov, v32_co;
  logic [31:0] v32_a, v32_b, v32_s;
`ifdef PIPE_ADDER_OVF_EN
  logic        v8_ovf, v32_ovf;
`endif

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst_sw), .in_valid(v8_iv), .in_ready(v8_ir),
    .a(v8_a), .b(v8_b), .cin(v8_c), .out_valid(v8_ov), .out_ready(1'b1),
    .sum(v8_s),
`ifdef PIPE_ADDER_OVF_EN
    .ovf(v8_ovf),
`endif
    .cout(v8_co)
  );

  pipe_adder #(.WIDTH(32), .STAGES(8)) u_dut32 (
    .clk(clk), .rst(rst_sw), .in_valid(v32_iv), .in_ready(v32_ir),
    .a(v32_a), .b(v32_b), .cin(v32_c), .out_valid(v32_ov), .out_ready(1'b1),
    .sum(v32_s),
`ifdef PIPE_ADDER_OVF_EN
    .ovf(v32_ovf),
`endif
    .cout(v32_co)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    logic       o;
    t = x + y + c;
    o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
`ifdef PIPE_ADDER_OVF_EN
    return {o, t};
`else
    return {1'b0, t};
`endif
  endfunction

  res_t act;
  assign act = {ovf_bit, cout, sum};

  // Scoreboard for the main DUT: push on accept, pop on emit.
  res_t exp_q[$];
  int   n_out = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
        else check("scoreboard", act, exp_q.pop_front());
      end
    end
  end

  // Sweep scoreboards carry the accept cycle to measure latency.
  logic [8:0]  e8;
  logic [32:0] e32;
  logic [8:0]  q8[$];
  logic [32:0] q32[$];
  int          t8[$], t32[$];
  int          n8_in = 0, n8_out = 0, n32_in = 0, n32_out = 0;

  always @(negedge clk) begin
    if (rst_sw) begin
      q8.delete(); t8.delete(); q32.delete(); t32.delete();
    end else begin
      if (v8_iv && v8_ir) begin
        e8 = v8_a + v8_b + v8_c;
        q8.push_back(e8); t8.push_back(cyc + 1); n8_in++;
      end
      if (v32_iv && v32_ir) begin
        e32 = v32_a + v32_b + v32_c;
        q32.push_back(e32); t32.push_back(cyc + 1); n32_in++;
      end
      if (v8_ov) begin
        n8_out++;
        if (q8.size() == 0) check("w8_unexpected", 64'd1, 64'd0);
        else begin
          check("w8_sum", {v8_co, v8_s}, q8.pop_front());
          check("w8_latency", cyc - t8.pop_front() + 1, 1);
        end
      end
      if (v32_ov) begin
        n32_out++;
        if (q32.size() == 0) check("w32_unexpected", 64'd1, 64'd0);
        else begin
          check("w32_sum", {v32_co, v32_s}, q32.pop_front());
          check("w32_latency", cyc - t32.pop_front() + 1, 8);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int t;
    a = x; b = y; cin = c; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- sweep stimulus ----------------
  logic sweep_done = 1'b0;

  initial begin
    v8_iv = 0; v8_a = 0; v8_b = 0; v8_c = 0;
    v32_iv = 0; v32_a = 0; v32_b = 0; v32_c = 0;
    repeat (3) @(posedge clk);
    #1 rst_sw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      v8_iv  = ($urandom_range(0, 3) != 0);
      v8_a   = 8'($urandom);
      v8_b   = 8'($urandom);
      v8_c   = 1'($urandom_range(0, 1));
      v32_iv = ($urandom_range(0, 3) != 0);
      v32_a  = $urandom;
      v32_b  = $urandom;
      v32_c  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    v8_iv = 0; v32_iv = 0;
    drain(12);
    check("w8_count", n8_out, n8_in);
    check("w32_count", n32_out, n32_in);
    check("w8_drained", q8.size(), 0);
    check("w32_drained", q32.size(), 0);
    sweep_done = 1'b1;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] va, vb;
    logic         vc;
    logic [W-1:0] es;
    logic         eco, eov;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    int n0, c0, lat, guard;
    bit done;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};

    in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_ovf", ovf_bit, 0);
    @(posedge clk);
    #1;

    // Single isolated transfers: latency and hand-computed results.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].va, vecs[i].vb, vecs[i].vc);
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, S);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].es);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].eco);
`ifdef PIPE_ADDER_OVF_EN
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].eov);
`endif
      drain(1);
    end

    // Back-to-back stream at full throughput.
    n0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 100; i++) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    check("b2b_cycles", cyc - c0, 100);
    drain(S + 2);
    check("b2b_count", n_out - n0, 100);
    check("b2b_drained", exp_q.size(), 0);

    // Backpressure: consumer stalls 5 cycles mid-stream.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 20; i++) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          if (exp_q.size() == 0) check("stall_queue_empty", 64'd1, 64'd0);
          else check("stall_hold", act, exp_q[0]);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain(S + 2);
    check("bp_count", n_out - n0, 20);
    check("bp_drained", exp_q.size(), 0);

    // Bubbles on input, random readiness on output.
    n0 = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("bubble_count", n_out - n0, 30);
    check("bubble_drained", exp_q.size(), 0);

    // Reset with three items in flight: nothing may emerge afterwards.
    send(16'h0101, 16'h0202, 1'b0);
    send(16'h0303, 16'h0404, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_sum", sum, 0);
    check("flush_cout", cout, 0);
    n0 = n_out;
    drain(10);
    check("flush_no_stale", n_out - n0, 0);

    guard = 0;
    while (!sweep_done && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    check("sweep_finished", sweep_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

endmodule
